ptpv2_bus_int_hub: RTL and testbench

Parametrised on-chip-bus and interrupt hub for multi-port PTPv2 cores. It decodes 32-bit bus accesses into NUM_CH per-channel register windows plus a local hub window, and returns registered read data with explicit acks in place of a wired-OR of sub-block read data. It also aggregates three interrupt sources per channel (xms, rx_ptp, tx_ptp) into sticky, maskable status and one interrupt output. It sits between the system bus and NUM_CH rtc/timestamp channel instances.

---
 rtl/ptpv2_bus_int_hub.sv | 174 +++++++++++++++++
 tb/tb_ptpv2_bus_int_hub.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ptpv2_bus_int_hub.sv
// ptpv2_bus_int_hub
//   Bus and interrupt hub for a multi-port PTPv2 core. Bus accesses are
//   decoded into NUM_CH channel windows (addr[11:8] = channel index) and a
//   hub window (addr[11:8] = 4'hF). Read data is returned with explicit
//   acks. Each channel's xms / rx_ptp / tx_ptp interrupt levels feed sticky,
//   maskable status bits that drive one registered interrupt.
//
// Ports
//   bus2ip_clk, bus2ip_rst        clock, synchronous active-high reset
//   bus2ip_addr_i/data_i          byte address / write data
//   bus2ip_rd_ce_i/wr_ce_i        one-cycle read / write requests
//   ip2bus_data_o                 read data, valid only while rdack is high
//   ip2bus_rdack_o/wrack_o        one-cycle completion pulses
//   ch_addr_o/ch_data_o           latched window offset / write data to channels
//   ch_rd_ce_o/ch_wr_ce_o         one-hot per-channel strobes
//   ch_ip2bus_data_i              channel read data, 32 bits per channel
//   ch_int_i                      3 interrupt levels per channel
//   int_o                         aggregated interrupt
module ptpv2_bus_int_hub #(
    parameter int          NUM_CH      = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  HUB_VERSION = 8'h02
) (
    input  logic                  bus2ip_clk,
    input  logic                  bus2ip_rst,
    input  logic [31:0]           bus2ip_addr_i,
    input  logic [31:0]           bus2ip_data_i,
    input  logic                  bus2ip_rd_ce_i,
    input  logic                  bus2ip_wr_ce_i,
    output logic [31:0]           ip2bus_data_o,
    output logic                  ip2bus_rdack_o,
    output logic                  ip2bus_wrack_o,
    output logic [11:0]           ch_addr_o,
    output logic [31:0]           ch_data_o,
    output logic [NUM_CH-1:0]     ch_rd_ce_o,
    output logic [NUM_CH-1:0]     ch_wr_ce_o,
    input  logic [32*NUM_CH-1:0]  ch_ip2bus_data_i,
    input  logic [3*NUM_CH-1:0]   ch_int_i,
    output logic                  int_o
);

    localparam int         NS   = 3 * NUM_CH;
    localparam logic [3:0] NCH4 = 4'(NUM_CH);
    localparam logic [7:0] NCH8 = 8'(NUM_CH);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [11:0]        lat_addr;
    logic [31:0]        lat_data;
    logic               lat_wr;
    logic               hit, accept;
    logic [3:0]         lat_win;
    logic               lat_is_ch, lat_is_hub;
    logic [NUM_CH-1:0]  lat_oh;
    logic [31:0]        ch_rdata;
    logic [31:0]        hub_rdata, hub_rdata_nxt;
    logic [NS-1:0]      int_prev, int_status, int_mask, int_rise, int_clr;
    logic               hub_wr;

    assign hit    = (bus2ip_addr_i[31:12] == BASE_ADDR[31:12]);
    // Only IDLE accepts; requests during ACCESS/RESP are silently dropped.
    assign accept = (state == IDLE) && hit && (bus2ip_rd_ce_i || bus2ip_wr_ce_i);

    assign lat_win    = lat_addr[11:8];
    assign lat_is_ch  = (lat_win < NCH4);
    assign lat_is_hub = (lat_win == 4'hF);

    // One-hot channel select; all zero for hub window and holes.
    always_comb begin
        lat_oh = '0;
        for (int c = 0; c < NUM_CH; c++)
            lat_oh[c] = lat_is_ch && (lat_win == 4'(c));
    end

    // Channel data is already registered inside the channel and valid in
    // RESP, so it is muxed straight through to keep the 2-cycle ack latency.
    always_comb begin
        ch_rdata = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (lat_oh[c]) ch_rdata = ch_rdata | ch_ip2bus_data_i[32*c +: 32];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) state <= IDLE;
        else            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ch_rd_ce_o     = '0;
        ch_wr_ce_o     = '0;
        ip2bus_rdack_o = 1'b0;
        ip2bus_wrack_o = 1'b0;
        ip2bus_data_o  = '0;
        case (state)
            ACCESS: begin
                if (lat_wr) ch_wr_ce_o = lat_oh;
                else        ch_rd_ce_o = lat_oh;
            end
            RESP: begin
                ip2bus_wrack_o = lat_wr;
                ip2bus_rdack_o = !lat_wr;
                if (!lat_wr) ip2bus_data_o = lat_is_hub ? hub_rdata : ch_rdata;
            end
            default: ;
        endcase
    end

    // Request latch; write wins when both strobes arrive together.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
        end else if (accept) begin
            lat_addr <= bus2ip_addr_i[11:0];
            lat_data <= bus2ip_data_i;
            lat_wr   <= bus2ip_wr_ce_i;
        end
    end

    assign ch_addr_o = lat_addr;
    assign ch_data_o = lat_data;

    // ---------------- hub registers ----------------
    always_comb begin
        case (lat_addr[7:0])
            8'h00:   hub_rdata_nxt = {16'h5054, HUB_VERSION, NCH8};
            8'h04:   hub_rdata_nxt = {{(32-NS){1'b0}}, ch_int_i};
            8'h08:   hub_rdata_nxt = {{(32-NS){1'b0}}, int_status};
            8'h0C:   hub_rdata_nxt = {{(32-NS){1'b0}}, int_mask};
            default: hub_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst)           hub_rdata <= '0;
        else if (state == ACCESS) hub_rdata <= hub_rdata_nxt;
    end

    // Hub writes commit at the end of RESP.
    assign hub_wr   = (state == RESP) && lat_wr && lat_is_hub;
    assign int_rise = ch_int_i & ~int_prev;
    assign int_clr  = (hub_wr && lat_addr[7:0] == 8'h08) ? lat_data[NS-1:0] : '0;

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            int_prev   <= '0;
            int_status <= '0;
            int_mask   <= '0;
            int_o      <= 1'b0;
        end else begin
            int_prev   <= ch_int_i;
            // OR-ing the rise after the clear lets a same-cycle edge win.
            int_status <= (int_status & ~int_clr) | int_rise;
            if (hub_wr && lat_addr[7:0] == 8'h0C) int_mask <= lat_data[NS-1:0];
            int_o      <= |(int_status & int_mask);
        end
    end

endmodule

// File: tb/tb_ptpv2_bus_int_hub.sv
// Directed bench for ptpv2_bus_int_hub (NUM_CH=4, BASE_ADDR=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ptpv2_bus_int_hub;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr, wdata;
    logic         rd_ce, wr_ce;
    logic [31:0]  rdata;
    logic         rdack, wrack;
    logic [11:0]  ch_addr;
    logic [31:0]  ch_data;
    logic [3:0]   ch_rd_ce, ch_wr_ce;
    logic [127:0] ch_rdata;
    logic [11:0]  ch_int;
    logic         int_o;

    int n_chk = 0;
    int n_err = 0;

    // snapshots taken by xfer at the three falling edges after a request
    logic [1:0]  a1, a2, a3;
    logic [3:0]  rdce1, wrce1, rdce2;
    logic [11:0] chaddr1;
    logic [31:0] chdata1, d2;

    always #5 clk = ~clk;

    ptpv2_bus_int_hub #(.NUM_CH(4), .BASE_ADDR(32'h0), .HUB_VERSION(8'h02)) dut (
        .bus2ip_clk       (clk),
        .bus2ip_rst       (rst),
        .bus2ip_addr_i    (addr),
        .bus2ip_data_i    (wdata),
        .bus2ip_rd_ce_i   (rd_ce),
        .bus2ip_wr_ce_i   (wr_ce),
        .ip2bus_data_o    (rdata),
        .ip2bus_rdack_o   (rdack),
        .ip2bus_wrack_o   (wrack),
        .ch_addr_o        (ch_addr),
        .ch_data_o        (ch_data),
        .ch_rd_ce_o       (ch_rd_ce),
        .ch_wr_ce_o       (ch_wr_ce),
        .ch_ip2bus_data_i (ch_rdata),
        .ch_int_i         (ch_int),
        .int_o            (int_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the third one.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        addr = a; wdata = d; rd_ce = rd; wr_ce = wr;
        @(negedge clk);
        rd_ce = 1'b0; wr_ce = 1'b0;
        a1 = {rdack, wrack}; rdce1 = ch_rd_ce; wrce1 = ch_wr_ce;
        chaddr1 = ch_addr; chdata1 = ch_data;
        @(negedge clk);
        a2 = {rdack, wrack}; d2 = rdata; rdce2 = ch_rd_ce;
        @(negedge clk);
        a3 = {rdack, wrack};
    endtask

    task automatic do_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        xfer(a, 32'h0, 1'b1, 1'b0);
        chk({tag, "_ack_early"}, 32'(a1), 32'h0);
        chk({tag, "_rdack"},     32'(a2), 32'h2);
        chk({tag, "_data"},      d2,      exp);
        chk({tag, "_ack_late"},  32'(a3), 32'h0);
    endtask

    task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        xfer(a, d, 1'b0, 1'b1);
        chk({tag, "_wrack"}, 32'(a2), 32'h1);
        chk({tag, "_data0"}, d2,      32'h0);
    endtask

    initial begin
        logic [2:0] acc;
        rst = 1'b1; addr = '0; wdata = '0; rd_ce = 1'b0; wr_ce = 1'b0;
        ch_int   = '0;
        ch_rdata = {32'h3333_3333, 32'hCAFE_0001, 32'h2222_2222, 32'h1111_1111};
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({rdack, wrack, ch_rd_ce, ch_wr_ce, int_o}), 32'h0);
        chk("rst_data", rdata, 32'h0);
        chk("rst_chaddr", 32'(ch_addr), 32'h0);
        chk("rst_chdata", ch_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ID
        do_rd("id", 32'h0000_0F00, 32'h5054_0204);

        // channel 2 read
        xfer(32'h0000_0210, 32'h0, 1'b1, 1'b0);
        chk("ch2_rdce", 32'(rdce1), 32'h4);
        chk("ch2_wrce", 32'(wrce1), 32'h0);
        chk("ch2_addr", 32'(chaddr1), 32'h210);
        chk("ch2_rdack", 32'(a2), 32'h2);
        chk("ch2_data", d2, 32'hCAFE_0001);
        chk("ch2_rdce_off", 32'(rdce2), 32'h0);

        // channel 1 write
        xfer(32'h0000_0104, 32'h0000_DEAD, 1'b0, 1'b1);
        chk("ch1_wrce", 32'(wrce1), 32'h2);
        chk("ch1_rdce", 32'(rdce1), 32'h0);
        chk("ch1_wdata", chdata1, 32'h0000_DEAD);
        chk("ch1_wrack", 32'(a2), 32'h1);

        // ch1 rx_ptp interrupt, masked
        ch_int[4] = 1'b1;
        repeat (2) @(negedge clk);
        do_rd("raw", 32'h0000_0F04, 32'h10);
        do_rd("sts1", 32'h0000_0F08, 32'h10);
        chk("int_masked", 32'(int_o), 32'h0);
        do_wr("mask10", 32'h0000_0F0C, 32'h10);
        chk("int_mask_lat", 32'(int_o), 32'h0);
        @(negedge clk);
        chk("int_on", 32'(int_o), 32'h1);
        do_wr("w1c10", 32'h0000_0F08, 32'h10);
        @(negedge clk);
        chk("int_off", 32'(int_o), 32'h0);
        do_rd("sts_clr", 32'h0000_0F08, 32'h0);
        chk("int_stay_off", 32'(int_o), 32'h0);

        // set bit 0, drop source, then clear it while a new edge arrives
        ch_int[4] = 1'b0;
        ch_int[0] = 1'b1;
        repeat (2) @(negedge clk);
        ch_int[0] = 1'b0;
        repeat (2) @(negedge clk);
        do_rd("sts_b0", 32'h0000_0F08, 32'h1);
        addr = 32'h0000_0F08; wdata = 32'h1; wr_ce = 1'b1;
        @(negedge clk);
        wr_ce = 1'b0;
        @(negedge clk);
        chk("race_wrack", 32'({rdack, wrack}), 32'h1);
        ch_int[0] = 1'b1;   // rising edge in the RESP cycle
        @(negedge clk);
        do_rd("race_sts", 32'h0000_0F08, 32'h1);

        // write+read together, plus a request during ACCESS
        addr = 32'h0000_0F0C; wdata = 32'hFFFF_FFFF; rd_ce = 1'b1; wr_ce = 1'b1;
        @(negedge clk);
        wr_ce = 1'b0; rd_ce = 1'b1; addr = 32'h0000_0F00;
        chk("both_strobe", 32'({ch_rd_ce, ch_wr_ce}), 32'h0);
        @(negedge clk);
        rd_ce = 1'b0;
        chk("both_ack", 32'({rdack, wrack}), 32'h1);
        acc = '0;
        repeat (2) begin
            @(negedge clk);
            acc = acc | {rdack, wrack, 1'b0};
        end
        chk("drop_noack", 32'(acc), 32'h0);
        do_rd("mask_fff", 32'h0000_0F0C, 32'h0000_0FFF);
        chk("int_b0", 32'(int_o), 32'h1);

        // unknown hub offset, hole and miss
        do_rd("hub_other", 32'h0000_0F10, 32'h0);
        do_rd("hole_rd", 32'h0000_0500, 32'h0);
        do_wr("hole_wr", 32'h0000_0500, 32'h1234_5678);
        chk("hole_wrce", 32'(wrce1), 32'h0);
        addr = 32'h0000_1000; rd_ce = 1'b1;
        @(negedge clk);
        rd_ce = 1'b0;
        acc = '0;
        repeat (4) begin
            acc = acc | {rdack, wrack, |ch_rd_ce};
            @(negedge clk);
        end
        chk("miss_noack", 32'(acc), 32'h0);

        // reset during ACCESS
        ch_int = '0;
        repeat (2) @(negedge clk);
        addr = 32'h0000_0210; rd_ce = 1'b1;
        @(negedge clk);
        rd_ce = 1'b0;
        chk("rstacc_strobe", 32'(ch_rd_ce), 32'h4);
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_ctl", 32'({rdack, wrack, ch_rd_ce, ch_wr_ce, int_o}), 32'h0);
        chk("rstacc_data", rdata, 32'h0);
        chk("rstacc_chaddr", 32'(ch_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstacc_noack", 32'({rdack, wrack, ch_rd_ce}), 32'h0);
        do_rd("rst_sts", 32'h0000_0F08, 32'h0);
        do_rd("rst_mask", 32'h0000_0F0C, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
